// File: rtl/router_pkg.sv
// Shared types for the router source receiver.
// State encoding, FIFO entry layout and address constants.
package router_pkg;

   localparam logic [1:0] ADDR_INVALID = 2'd3;
   localparam int FIFO_DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE,
      PAYLOAD,
      PARITY,
      DROP
   } rx_state_t;

   typedef struct packed {
      logic [1:0] dest;
      logic       sop;
      logic       eop;
      logic       bad;
      logic [7:0] data;
   } fifo_ent_t;

endpackage

// File: rtl/router_src_rx_if.sv
// Output beat stream of the receiver: entry, valid and ready.
// The FIFO drives the master side, the consumer the slave side.
interface router_src_rx_if;
   import router_pkg::*;

   fifo_ent_t ent;
   logic      valid;
   logic      ready;

   modport master (output ent, output valid, input ready);
   modport slave  (input ent, input valid, output ready);

endinterface

// File: rtl/router_rx_fifo.sv
// Synchronous circular FIFO of payload beats with occupancy count.
// Read data is presented from the storage array once count is non-zero.
module router_rx_fifo
   import router_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH_DEF,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              push,
   input  fifo_ent_t         wdata,
   router_src_rx_if.master   rd,
   output logic [CW-1:0]     count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fifo_ent_t      mem [DEPTH];
   logic [AW-1:0]  wp;
   logic [AW-1:0]  rp;
   logic           full;
   logic           wr;
   logic           rd_en;

   assign full  = (count == CW'(DEPTH));
   assign wr    = push && !full;
   assign rd_en = rd.valid && rd.ready;

   assign rd.valid = (count != '0);
   assign rd.ent   = rd.valid ? mem[rp] : '0;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr)
            wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
         if (rd_en)
            rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
         unique case ({wr, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr)
         mem[wp] <= wdata;
   end

endmodule

// File: rtl/router_src_rx.sv
// Source-side packet receiver: header decode, length/parity check,
// one-entry skid register and output FIFO of tagged payload beats.
module router_src_rx
   import router_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] data_in,
   input  logic       pkt_valid,
   output logic       busy,
   output logic       err,
   output logic [7:0] dout,
   output logic [1:0] dout_dest,
   output logic       dout_sop,
   output logic       dout_eop,
   output logic       dout_bad,
   output logic       dout_valid,
   input  logic       dout_ready
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   rx_state_t      state;
   rx_state_t      state_nx;
   logic [5:0]     cnt;
   logic [7:0]     par;
   logic [1:0]     dest_q;
   logic           first;
   logic           hold_vld;
   logic           hold_sop;
   logic [7:0]     hold_data;
   logic [CW-1:0]  fcount;
   logic           accept;
   logic           push;
   logic           bad_now;
   fifo_ent_t      push_ent;
   logic [5:0]     hdr_len;
   logic [1:0]     hdr_dest;

   router_src_rx_if ob ();

   router_rx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .wdata  (push_ent),
      .rd     (ob),
      .count  (fcount)
   );

   assign ob.ready   = dout_ready;
   assign dout       = ob.ent.data;
   assign dout_dest  = ob.ent.dest;
   assign dout_sop   = ob.ent.sop;
   assign dout_eop   = ob.ent.eop;
   assign dout_bad   = ob.ent.bad;
   assign dout_valid = ob.valid;

   // One slot of headroom is kept for the byte still in the skid register.
   assign busy     = (fcount >= CW'(FIFO_DEPTH - 1));
   assign accept   = !busy && ((state != IDLE) || pkt_valid);
   assign hdr_len  = data_in[7:2];
   assign hdr_dest = data_in[1:0];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      push     = 1'b0;
      bad_now  = (par != data_in) || pkt_valid;
      push_ent = '{dest: dest_q, sop: hold_sop, eop: 1'b0,
                   bad: 1'b0, data: hold_data};
      if (accept) begin
         unique case (state)
            IDLE: begin
               if (hdr_dest == ADDR_INVALID)
                  state_nx = DROP;
               else if (hdr_len == 6'd0)
                  state_nx = PARITY;
               else
                  state_nx = PAYLOAD;
            end
            PAYLOAD: begin
               push = hold_vld;
               // Early pkt_valid drop: this byte closes the packet as bad.
               if (!pkt_valid) begin
                  push_ent.eop = 1'b1;
                  push_ent.bad = 1'b1;
                  state_nx     = IDLE;
               end else if (cnt == 6'd1) begin
                  state_nx = PARITY;
               end
            end
            PARITY: begin
               push         = hold_vld;
               push_ent.eop = 1'b1;
               push_ent.bad = bad_now;
               state_nx     = IDLE;
            end
            DROP: begin
               if (cnt == 6'd0)
                  state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt       <= '0;
         par       <= '0;
         dest_q    <= '0;
         first     <= 1'b0;
         hold_vld  <= 1'b0;
         hold_sop  <= 1'b0;
         hold_data <= '0;
         err       <= 1'b0;
      end else if (accept) begin
         unique case (state)
            IDLE: begin
               par      <= data_in;
               cnt      <= hdr_len;
               dest_q   <= hdr_dest;
               first    <= 1'b1;
               hold_vld <= 1'b0;
               err      <= 1'b0;
            end
            PAYLOAD: begin
               if (pkt_valid) begin
                  par       <= par ^ data_in;
                  cnt       <= cnt - 6'd1;
                  hold_data <= data_in;
                  hold_sop  <= first;
                  hold_vld  <= 1'b1;
                  first     <= 1'b0;
               end else begin
                  cnt      <= '0;
                  hold_vld <= 1'b0;
                  err      <= 1'b1;
               end
            end
            PARITY: begin
               hold_vld <= 1'b0;
               err      <= bad_now;
            end
            DROP: begin
               if (cnt == 6'd0)
                  err <= 1'b1;
               else
                  cnt <= cnt - 6'd1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_src_rx.sv
// Randomized bench for router_src_rx with a packet-level reference model.
// Expected beats are queued per packet and matched by an output monitor.
module tb_router_src_rx;
   import router_pkg::*;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] data_in = '0;
   logic       pkt_valid = 1'b0;
   logic       busy;
   logic       err;
   logic [7:0] dout;
   logic [1:0] dout_dest;
   logic       dout_sop;
   logic       dout_eop;
   logic       dout_bad;
   logic       dout_valid;
   logic       dout_ready = 1'b0;

   int n_chk = 0;
   int n_err = 0;
   int rdy_mode = 1;
   fifo_ent_t  exp_q [$];
   logic [7:0] pl_q [$];

   router_src_rx_if mon ();

   always #5 clk = ~clk;

   router_src_rx dut (
      .clk        (clk),
      .resetn     (resetn),
      .data_in    (data_in),
      .pkt_valid  (pkt_valid),
      .busy       (busy),
      .err        (err),
      .dout       (dout),
      .dout_dest  (dout_dest),
      .dout_sop   (dout_sop),
      .dout_eop   (dout_eop),
      .dout_bad   (dout_bad),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
   );

   assign mon.ent   = {dout_dest, dout_sop, dout_eop, dout_bad, dout};
   assign mon.valid = dout_valid;
   assign mon.ready = dout_ready;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Ready is chosen and the handshake judged in the same process.
   always @(negedge clk) begin
      fifo_ent_t e;
      if (rdy_mode == 0)
         dout_ready = 1'b0;
      else if (rdy_mode == 1)
         dout_ready = 1'b1;
      else
         dout_ready = 1'($urandom_range(0, 1));
      if (resetn && mon.valid && dout_ready) begin
         chk("beat_expected", 32'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat", 32'(mon.ent), 32'(e));
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic put(logic [7:0] d, logic v);
      int n;
      n = 0;
      data_in   = d;
      pkt_valid = v;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000)
         chk("busy_timeout", 32'(busy), 0);
      @(negedge clk);
   endtask

   task automatic idle(int k);
      pkt_valid = 1'b0;
      data_in   = 8'($urandom);
      repeat (k) @(negedge clk);
   endtask

   // Packet-level expectation: beats from the sent payload, bad on the last.
   function automatic bit model_pkt(logic [7:0] hdr, logic [7:0] p,
                                    logic pv);
      int         len;
      logic [1:0] dst;
      logic [7:0] x;
      bit         bad;
      fifo_ent_t  e;
      len = int'(hdr[7:2]);
      dst = hdr[1:0];
      x   = hdr;
      foreach (pl_q[i]) x ^= pl_q[i];
      bad = (dst == ADDR_INVALID) || pv || (pl_q.size() < len) || (p != x);
      if (dst != ADDR_INVALID) begin
         foreach (pl_q[i]) begin
            e.data = pl_q[i];
            e.dest = dst;
            e.sop  = (i == 0);
            e.eop  = (i == pl_q.size() - 1);
            e.bad  = e.eop && bad;
            exp_q.push_back(e);
         end
      end
      return bad;
   endfunction

   task automatic send_pkt(logic [7:0] hdr, logic [7:0] p, logic pv);
      bit eb;
      eb = model_pkt(hdr, p, pv);
      put(hdr, 1'b1);
      chk("err_clear", 32'(err), 0);
      foreach (pl_q[i]) put(pl_q[i], 1'b1);
      put(p, pv);
      chk("err_pkt", 32'(err), 32'(eb));
   endtask

   task automatic drain();
      int n;
      n = 0;
      rdy_mode = 1;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("drain", exp_q.size(), 0);
      @(negedge clk);
      chk("fifo_empty", 32'(dout_valid), 0);
   endtask

   function automatic logic [7:0] xor_pkt(logic [7:0] hdr);
      logic [7:0] x;
      x = hdr;
      foreach (pl_q[i]) x ^= pl_q[i];
      return x;
   endfunction

   initial begin
      logic [7:0] hdr;
      logic [7:0] p;
      int len;
      int dst;
      int kind;
      int n;

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_valid", 32'(dout_valid), 0);
      chk("rst_flags", 32'({dout_sop, dout_eop, dout_bad}), 0);
      resetn = 1'b1;
      idle(2);

      pl_q = '{8'hAA, 8'hBB, 8'hCC};
      send_pkt(8'h0D, 8'hD0, 1'b0);
      idle(2);
      pl_q = '{8'hAA, 8'hBB, 8'hCC};
      send_pkt(8'h0D, 8'hD1, 1'b0);
      idle(3);
      chk("err_hold", 32'(err), 1);
      pl_q = '{8'h5A};
      send_pkt(8'h07, 8'h00, 1'b0);
      pl_q = '{};
      send_pkt(8'h01, 8'h01, 1'b0);
      drain();

      // Backpressure: fill the FIFO with ready held low.
      rdy_mode = 0;
      @(negedge clk);
      pl_q = '{};
      repeat (20) pl_q.push_back(8'($urandom));
      p = xor_pkt(8'h50);
      void'(model_pkt(8'h50, p, 1'b0));
      put(8'h50, 1'b1);
      for (int i = 0; i < 15; i++) put(pl_q[i], 1'b1);
      chk("busy_pre", 32'(busy), 0);
      put(pl_q[15], 1'b1);
      chk("busy_full", 32'(busy), 1);
      chk("valid_full", 32'(dout_valid), 1);
      repeat (4) @(negedge clk);
      chk("busy_hold", 32'(busy), 1);
      rdy_mode = 1;
      for (int i = 16; i < 20; i++) put(pl_q[i], 1'b1);
      put(p, 1'b0);
      chk("err_long", 32'(err), 0);
      drain();

      // Reset in the middle of a length-5 packet.
      rdy_mode = 0;
      @(negedge clk);
      put(8'h16, 1'b1);
      put(8'h11, 1'b1);
      put(8'h22, 1'b1);
      chk("mid_valid", 32'(dout_valid), 1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(dout_valid), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_err", 32'(err), 0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      rdy_mode = 1;
      idle(1);
      pl_q = '{8'h31, 8'h42, 8'h53};
      send_pkt(8'h0E, xor_pkt(8'h0E), 1'b0);
      drain();

      for (int k = 0; k < 40; k++) begin
         len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63)
                                            : $urandom_range(0, 6);
         dst  = $urandom_range(0, 3);
         kind = $urandom_range(0, 3);
         if (dst == 3 && kind == 3) kind = 0;
         if (len == 0 && kind == 3) kind = 1;
         n = (kind == 3) ? $urandom_range(0, len - 1) : len;
         hdr = {len[5:0], dst[1:0]};
         pl_q = '{};
         repeat (n) pl_q.push_back(8'($urandom));
         p = xor_pkt(hdr);
         if (kind == 1) p = p ^ 8'($urandom_range(1, 255));
         if (kind == 3) p = 8'($urandom);
         rdy_mode = $urandom_range(1, 2);
         send_pkt(hdr, p, 1'(kind == 2));
         idle($urandom_range(0, 3));
      end
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
